// File: rtl/uart_cmd_decoder.sv
// Receive-side command parser for the alarm clock: decodes load-time, load-alarm
// and arm-toggle commands from the UART byte stream and returns a one-byte ack.
module uart_cmd_decoder #(
  parameter logic [23:0] TIMEOUT = 24'd12_000_000,
  parameter logic [7:0]  ACK_OK  = 8'h4B,
  parameter logic [7:0]  ACK_ERR = 8'h3F
) (
  input  logic        clk12m,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic        ld_time,
  output logic        ld_alarm,
  output logic [15:0] time_bcd,
  output logic        alarm_en,
  output logic [7:0]  tx_data,
  output logic        tx_data_rdy,
  output logic        busy
);

  localparam int unsigned ByteW  = 8;
  localparam int unsigned BcdW   = 16;
  localparam int unsigned DigitW = 4;
  localparam int unsigned CntW   = 2;
  localparam int unsigned TmoW   = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIGITS  = 2'd1,
    ST_WAIT_CR = 2'd2
  } state_t;

  typedef enum logic {
    CMD_TIME  = 1'b0,
    CMD_ALARM = 1'b1
  } cmd_t;

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BcdW-1:0]    buf_q, buf_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [BcdW-1:0]    time_bcd_q, time_bcd_d;
  logic               alarm_en_q, alarm_en_d;
  logic               ld_time_q, ld_time_d;
  logic               ld_alarm_q, ld_alarm_d;
  logic [ByteW-1:0]   tx_data_q, tx_data_d;
  logic               tx_rdy_q, tx_rdy_d;
  logic               busy_q, busy_d;

  logic               is_digit;
  logic [DigitW-1:0]  digit;
  logic [DigitW-1:0]  digit_max;

  // Tens positions (0 and 2) allow 0..5, ones positions allow 0..9
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign digit     = DigitW'(rx_data - 8'h30);
  assign digit_max = cnt_q[0] ? 4'd9 : 4'd5;

  always_ff @(posedge clk12m) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_TIME;
      cnt_q      <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      time_bcd_q <= '0;
      alarm_en_q <= 1'b0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      tx_data_q  <= '0;
      tx_rdy_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      tmo_q      <= tmo_d;
      time_bcd_q <= time_bcd_d;
      alarm_en_q <= alarm_en_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      tx_data_q  <= tx_data_d;
      tx_rdy_q   <= tx_rdy_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    tmo_d      = tmo_q;
    time_bcd_d = time_bcd_q;
    alarm_en_d = alarm_en_q;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_rdy_d   = 1'b0;

    if (rx_data_rdy) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (rx_data)
            8'h6C, 8'h4C: begin
              cmd_d   = CMD_TIME;
              cnt_d   = '0;
              buf_d   = '0;
              state_d = ST_DIGITS;
            end
            8'h61, 8'h41: begin
              cmd_d   = CMD_ALARM;
              cnt_d   = '0;
              buf_d   = '0;
              state_d = ST_DIGITS;
            end
            8'h40: begin
              alarm_en_d = ~alarm_en_q;
              tx_data_d  = ACK_OK;
              tx_rdy_d   = 1'b1;
            end
            8'h0D, 8'h0A, 8'h20: begin
            end
            default: begin
              tx_data_d = ACK_ERR;
              tx_rdy_d  = 1'b1;
            end
          endcase
        end
        ST_DIGITS: begin
          if (is_digit && (digit <= digit_max)) begin
            buf_d = {buf_q[BcdW-DigitW-1:0], digit};
            if (cnt_q == 2'd3) begin
              cnt_d   = '0;
              state_d = ST_WAIT_CR;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end else begin
            tx_data_d = ACK_ERR;
            tx_rdy_d  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_WAIT_CR: begin
          if (rx_data == 8'h0D) begin
            time_bcd_d = buf_q;
            ld_time_d  = (cmd_q == CMD_TIME);
            ld_alarm_d = (cmd_q == CMD_ALARM);
            tx_data_d  = ACK_OK;
          end else begin
            tx_data_d  = ACK_ERR;
          end
          tx_rdy_d = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A byte in the expiry cycle takes the branch above, so it wins over abort
      if (tmo_q >= TIMEOUT - 24'd1) begin
        tmo_d     = '0;
        tx_data_d = ACK_ERR;
        tx_rdy_d  = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 24'd1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign ld_time     = ld_time_q;
  assign ld_alarm    = ld_alarm_q;
  assign time_bcd    = time_bcd_q;
  assign alarm_en    = alarm_en_q;
  assign tx_data     = tx_data_q;
  assign tx_data_rdy = tx_rdy_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a short timeout.
module tb_uart_cmd_decoder;

  localparam logic [23:0] TMO = 24'd100;
  localparam logic [7:0]  CR  = 8'h0D;

  logic        clk12m = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_rdy = 1'b0;
  logic        ld_time, ld_alarm, alarm_en, tx_data_rdy, busy;
  logic [15:0] time_bcd;
  logic [7:0]  tx_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ok_cnt = 0, err_cnt = 0, ldt_cnt = 0, lda_cnt = 0;

  uart_cmd_decoder #(.TIMEOUT(TMO), .ACK_OK(8'h4B), .ACK_ERR(8'h3F)) dut (
    .clk12m(clk12m), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .ld_time(ld_time), .ld_alarm(ld_alarm), .time_bcd(time_bcd), .alarm_en(alarm_en),
    .tx_data(tx_data), .tx_data_rdy(tx_data_rdy), .busy(busy)
  );

  always #5 clk12m = ~clk12m;

  // Pulse tallies, sampled mid-cycle
  always @(negedge clk12m) begin
    if (tx_data_rdy && tx_data == 8'h4B) ok_cnt++;
    if (tx_data_rdy && tx_data == 8'h3F) err_cnt++;
    if (ld_time) ldt_cnt++;
    if (ld_alarm) lda_cnt++;
  end

  // Returns 1 ns after the edge that consumed the byte: outputs reflect it
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_data_rdy = 1'b1;
    @(posedge clk12m); #1;
    rx_data_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk12m); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    total_cnt++; if (time_bcd !== 16'h0000) $display("FAIL reset_time_bcd got %h want 0000", time_bcd); else pass_cnt++;
    total_cnt++; if ({alarm_en, ld_time, ld_alarm, tx_data_rdy, busy} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {alarm_en, ld_time, ld_alarm, tx_data_rdy, busy}); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else pass_cnt++;
  endtask

  task automatic test_load_time;
    send(8'h6C);
    total_cnt++; if (busy !== 1'b1) $display("FAIL lt_busy got %b want 1", busy); else pass_cnt++;
    send(8'h35); send(8'h39); send(8'h31); send(8'h30);
    total_cnt++; if (ld_time !== 1'b0 || tx_data_rdy !== 1'b0) $display("FAIL lt_early got %b%b want 00", ld_time, tx_data_rdy); else pass_cnt++;
    send(CR);
    total_cnt++; if (ld_time !== 1'b1) $display("FAIL lt_ld_time got %b want 1", ld_time); else pass_cnt++;
    total_cnt++; if (time_bcd !== 16'h5910) $display("FAIL lt_time_bcd got %h want 5910", time_bcd); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h4B || tx_data_rdy !== 1'b1) $display("FAIL lt_ack got %h/%b want 4b/1", tx_data, tx_data_rdy); else pass_cnt++;
    total_cnt++; if (ld_alarm !== 1'b0) $display("FAIL lt_ld_alarm got %b want 0", ld_alarm); else pass_cnt++;
    idle(1);
    total_cnt++; if ({ld_time, tx_data_rdy, busy} !== 3'b000) $display("FAIL lt_after got %b want 000", {ld_time, tx_data_rdy, busy}); else pass_cnt++;
    total_cnt++; if (time_bcd !== 16'h5910) $display("FAIL lt_hold got %h want 5910", time_bcd); else pass_cnt++;
  endtask

  task automatic test_load_alarm_arm;
    send(8'h61); idle(1); send(8'h35); idle(1); send(8'h39); idle(1);
    send(8'h32); idle(1); send(8'h30); idle(1);
    send(CR);
    total_cnt++; if (ld_alarm !== 1'b1 || ld_time !== 1'b0) $display("FAIL la_strobe got %b%b want 10", ld_alarm, ld_time); else pass_cnt++;
    total_cnt++; if (time_bcd !== 16'h5920) $display("FAIL la_time_bcd got %h want 5920", time_bcd); else pass_cnt++;
    total_cnt++; if (alarm_en !== 1'b0) $display("FAIL la_no_arm got %b want 0", alarm_en); else pass_cnt++;
    idle(1);
    send(8'h40);
    total_cnt++; if (alarm_en !== 1'b1) $display("FAIL arm_on got %b want 1", alarm_en); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h4B || tx_data_rdy !== 1'b1) $display("FAIL arm_ack got %h/%b want 4b/1", tx_data, tx_data_rdy); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL arm_busy got %b want 0", busy); else pass_cnt++;
    idle(2);
    send(8'h40);
    total_cnt++; if (alarm_en !== 1'b0) $display("FAIL arm_off got %b want 0", alarm_en); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_range_err;
    int e0, l0;
    send(8'h6C); send(8'h36);
    total_cnt++; if (tx_data !== 8'h3F || tx_data_rdy !== 1'b1) $display("FAIL rng_ack got %h/%b want 3f/1", tx_data, tx_data_rdy); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rng_busy got %b want 0", busy); else pass_cnt++;
    idle(1);
    e0 = err_cnt; l0 = ldt_cnt;
    send(8'h30); send(8'h30); send(8'h30); send(CR);
    idle(2);
    total_cnt++; if (ldt_cnt - l0 !== 0) $display("FAIL rng_no_load got %0d want 0", ldt_cnt - l0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 3) $display("FAIL rng_stray_err got %0d want 3", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (time_bcd !== 16'h5920) $display("FAIL rng_hold got %h want 5920", time_bcd); else pass_cnt++;
  endtask

  task automatic test_extra_digit;
    int l0;
    l0 = ldt_cnt;
    send(8'h4C); send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    total_cnt++; if (busy !== 1'b1) $display("FAIL xd_wait_cr got %b want 1", busy); else pass_cnt++;
    send(8'h35);
    total_cnt++; if (tx_data !== 8'h3F || tx_data_rdy !== 1'b1 || busy !== 1'b0) $display("FAIL xd_err got %h/%b/%b want 3f/1/0", tx_data, tx_data_rdy, busy); else pass_cnt++;
    idle(2);
    total_cnt++; if (ldt_cnt - l0 !== 0 || time_bcd !== 16'h5920) $display("FAIL xd_no_load got %0d/%h want 0/5920", ldt_cnt - l0, time_bcd); else pass_cnt++;
  endtask

  task automatic test_ignore;
    int e0, o0;
    e0 = err_cnt; o0 = ok_cnt;
    send(8'h20); send(8'h0A); send(CR);
    idle(2);
    total_cnt++; if (err_cnt - e0 !== 0 || ok_cnt - o0 !== 0 || busy !== 1'b0) $display("FAIL ign got err %0d ok %0d busy %b want 0 0 0", err_cnt - e0, ok_cnt - o0, busy); else pass_cnt++;
  endtask

  task automatic test_timeout;
    int e0;
    send(8'h61); send(8'h31); send(8'h32);
    e0 = err_cnt;
    idle(int'(TMO) - 2);
    total_cnt++; if (err_cnt - e0 !== 0 || busy !== 1'b1) $display("FAIL tmo_early got err %0d busy %b want 0 1", err_cnt - e0, busy); else pass_cnt++;
    idle(10);
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL tmo_err_count got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL tmo_busy got %b want 0", busy); else pass_cnt++;
    send(8'h61); send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(CR);
    total_cnt++; if (ld_alarm !== 1'b1 || time_bcd !== 16'h1234) $display("FAIL tmo_reload got %b/%h want 1/1234", ld_alarm, time_bcd); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_timeout_edge;
    int e0;
    send(8'h41); send(8'h34);
    e0 = err_cnt;
    idle(int'(TMO) - 1);
    send(8'h35);
    total_cnt++; if (busy !== 1'b1 || tx_data_rdy !== 1'b0) $display("FAIL edge_byte_wins got busy %b rdy %b want 1 0", busy, tx_data_rdy); else pass_cnt++;
    send(8'h33); send(8'h30); send(CR);
    total_cnt++; if (ld_alarm !== 1'b1 || time_bcd !== 16'h4530) $display("FAIL edge_load got %b/%h want 1/4530", ld_alarm, time_bcd); else pass_cnt++;
    idle(1);
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL edge_no_abort got %0d want 0", err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int l0;
    send(8'h40);
    idle(1);
    total_cnt++; if (alarm_en !== 1'b1) $display("FAIL rm_armed got %b want 1", alarm_en); else pass_cnt++;
    l0 = ldt_cnt;
    send(8'h6C); send(8'h30); send(8'h31);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    total_cnt++; if ({alarm_en, ld_time, ld_alarm, tx_data_rdy, busy} !== 5'b0) $display("FAIL rm_flags got %b want 00000", {alarm_en, ld_time, ld_alarm, tx_data_rdy, busy}); else pass_cnt++;
    total_cnt++; if (time_bcd !== 16'h0000 || tx_data !== 8'h00) $display("FAIL rm_data got %h/%h want 0000/00", time_bcd, tx_data); else pass_cnt++;
    idle(2);
    total_cnt++; if (ldt_cnt - l0 !== 0 || tx_data_rdy !== 1'b0) $display("FAIL rm_no_strobe got %0d/%b want 0/0", ldt_cnt - l0, tx_data_rdy); else pass_cnt++;
    send(8'h6C); send(8'h30); send(8'h31); send(8'h30); send(8'h32); send(CR);
    total_cnt++; if (ld_time !== 1'b1 || time_bcd !== 16'h0102) $display("FAIL rm_reload got %b/%h want 1/0102", ld_time, time_bcd); else pass_cnt++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_load_time();
    test_load_alarm_arm();
    test_range_err();
    test_extra_digit();
    test_ignore();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
